// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 active-low keypad scanner with per-frame debounce and decimal operand entry.
// Build option KEYPAD_BACKSPACE_EN makes '*' a backspace instead of a clear.
module keypad_entry #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_CNT   = 12,
  parameter int DEBOUNCE   = 3,
  parameter int DATA_W     = 11,
  parameter int MAX_DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROWS-1:0]   rows,
  output logic [COLS-1:0]   cols,
  output logic [3:0]        key_code,
  output logic              key_valid,
  output logic [DATA_W-1:0] value,
  output logic [2:0]        digit_cnt,
  output logic [DATA_W-1:0] operand,
  output logic [1:0]        op_code,
  output logic              op_valid,
  output logic              enter,
  output logic              overflow
);

  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam int PW    = DATA_W + 4;

  typedef enum logic [1:0] {
    S_RELEASED,
    S_PRESS_WAIT,
    S_HELD,
    S_REL_WAIT
  } state_t;

  // Scan and frame accumulation
  logic [SCAN_CNT-1:0] r_div;
  logic [CW-1:0]       r_col;
  logic [ROWS-1:0]     r_rows_meta;
  logic [ROWS-1:0]     r_rows_sync;
  logic [1:0]          r_hits;
  logic [RW-1:0]       r_hit_row;
  logic [CW-1:0]       r_hit_col;

  logic                w_tick;
  logic                w_col_last;
  logic                w_frame_end;
  logic                w_low_any;
  logic                w_low_many;
  logic [RW-1:0]       w_low_row;
  logic [1:0]          w_hits_nxt;
  logic [RW-1:0]       w_row_nxt;
  logic [CW-1:0]       w_col_nxt;
  logic                w_res_key;
  logic [3:0]          w_res_code;

  // Debounce FSM
  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [3:0]          r_cand;
  logic [3:0]          w_cand_nxt;
  logic [3:0]          r_key_code;
  logic                r_key_valid;
  logic                w_accept;
  logic [3:0]          w_accept_code;

  // Operand accumulator
  logic [DATA_W-1:0]   r_value;
  logic [2:0]          r_digit_cnt;
  logic [DATA_W-1:0]   r_operand;
  logic [1:0]          r_op_code;
  logic                r_op_valid;
  logic                r_enter;
  logic                r_overflow;
  logic                w_is_digit;
  logic [PW-1:0]       w_prod;
  logic                w_digit_ok;

  function automatic logic [3:0] key_map(input logic [RW-1:0] row, input logic [CW-1:0] col);
    logic [3:0] idx;
    idx = {2'(row), 2'(col)};
    key_map = 4'd0;
    case (idx)
      4'd0:  key_map = 4'd1;
      4'd1:  key_map = 4'd2;
      4'd2:  key_map = 4'd3;
      4'd3:  key_map = 4'd10;
      4'd4:  key_map = 4'd4;
      4'd5:  key_map = 4'd5;
      4'd6:  key_map = 4'd6;
      4'd7:  key_map = 4'd11;
      4'd8:  key_map = 4'd7;
      4'd9:  key_map = 4'd8;
      4'd10: key_map = 4'd9;
      4'd11: key_map = 4'd12;
      4'd12: key_map = 4'd14;
      4'd13: key_map = 4'd0;
      4'd14: key_map = 4'd15;
      default: key_map = 4'd13;
    endcase
  endfunction

  assign w_tick      = &r_div;
  assign w_col_last  = (r_col == CW'(COLS - 1));
  assign w_frame_end = w_tick && w_col_last;
  assign cols        = ~(COLS'(1) << r_col);

  always_comb begin
    w_low_any  = 1'b0;
    w_low_many = 1'b0;
    w_low_row  = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!r_rows_sync[r]) begin
        if (w_low_any) w_low_many = 1'b1;
        w_low_any = 1'b1;
        w_low_row = RW'(r);
      end
    end
  end

  // r_hits: 0 = nothing seen, 1 = exactly one key, 2 = more than one key
  always_comb begin
    w_hits_nxt = r_hits;
    w_row_nxt  = r_hit_row;
    w_col_nxt  = r_hit_col;
    if (w_low_many) begin
      w_hits_nxt = 2'd2;
    end else if (w_low_any) begin
      if (r_hits == 2'd0) begin
        w_hits_nxt = 2'd1;
        w_row_nxt  = w_low_row;
        w_col_nxt  = r_col;
      end else begin
        w_hits_nxt = 2'd2;
      end
    end
  end

  assign w_res_key  = (w_hits_nxt == 2'd1);
  assign w_res_code = key_map(w_row_nxt, w_col_nxt);

  // rows is an off-chip async input; two flops settle well within one scan tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div       <= '0;
      r_col       <= '0;
      r_rows_meta <= '1;
      r_rows_sync <= '1;
      r_hits      <= 2'd0;
      r_hit_row   <= '0;
      r_hit_col   <= '0;
    end else begin
      r_div       <= r_div + SCAN_CNT'(1);
      r_rows_meta <= rows;
      r_rows_sync <= r_rows_meta;
      if (w_tick) begin
        r_col <= w_col_last ? '0 : r_col + CW'(1);
        if (w_col_last) begin
          r_hits <= 2'd0;
        end else begin
          r_hits    <= w_hits_nxt;
          r_hit_row <= w_row_nxt;
          r_hit_col <= w_col_nxt;
        end
      end
    end
  end

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_cand_nxt    = r_cand;
    w_accept      = 1'b0;
    w_accept_code = r_cand;
    if (w_frame_end) begin
      case (r_state)
        S_RELEASED: begin
          if (w_res_key) begin
            w_cand_nxt = w_res_code;
            w_cnt_nxt  = CNT_W'(1);
            if (DEBOUNCE <= 1) begin
              w_state_nxt   = S_HELD;
              w_accept      = 1'b1;
              w_accept_code = w_res_code;
            end else begin
              w_state_nxt = S_PRESS_WAIT;
            end
          end
        end
        S_PRESS_WAIT: begin
          if (w_res_key && (w_res_code == r_cand)) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc >= CNT_W'(DEBOUNCE)) begin
              w_state_nxt = S_HELD;
              w_accept    = 1'b1;
            end
          end else begin
            w_state_nxt = S_RELEASED;
          end
        end
        S_HELD: begin
          if (!w_res_key) begin
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = (DEBOUNCE <= 1) ? S_RELEASED : S_REL_WAIT;
          end
        end
        S_REL_WAIT: begin
          if (!w_res_key) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc >= CNT_W'(DEBOUNCE)) w_state_nxt = S_RELEASED;
          end else begin
            w_state_nxt = S_HELD;
          end
        end
        default: w_state_nxt = S_RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_RELEASED;
      r_cnt       <= '0;
      r_cand      <= 4'd0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cand      <= w_cand_nxt;
      r_key_valid <= w_accept;
      if (w_accept) r_key_code <= w_accept_code;
    end
  end

  // Product is formed 4 bits wider so value*10+d cannot wrap before the range check
  assign w_is_digit = (r_key_code <= 4'd9);
  assign w_prod     = PW'(r_value) * PW'(10) + PW'(r_key_code);
  assign w_digit_ok = (r_digit_cnt < 3'(MAX_DIGITS)) && (w_prod <= {4'b0, {DATA_W{1'b1}}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_value     <= '0;
      r_digit_cnt <= 3'd0;
      r_operand   <= '0;
      r_op_code   <= 2'd0;
      r_op_valid  <= 1'b0;
      r_enter     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_op_valid <= 1'b0;
      r_enter    <= 1'b0;
      r_overflow <= 1'b0;
      if (r_key_valid) begin
        if (w_is_digit) begin
          if (w_digit_ok) begin
            r_value     <= w_prod[DATA_W-1:0];
            r_digit_cnt <= r_digit_cnt + 3'd1;
          end else begin
            r_overflow <= 1'b1;
          end
        end else begin
          case (r_key_code)
            4'd14: begin
`ifdef KEYPAD_BACKSPACE_EN
              if (r_digit_cnt != 3'd0) begin
                r_value     <= r_value / DATA_W'(10);
                r_digit_cnt <= r_digit_cnt - 3'd1;
              end
`else
              r_value     <= '0;
              r_digit_cnt <= 3'd0;
`endif
            end
            4'd15: begin
              r_operand   <= r_value;
              r_enter     <= 1'b1;
              r_value     <= '0;
              r_digit_cnt <= 3'd0;
            end
            default: begin
              r_operand   <= r_value;
              r_op_code   <= 2'(r_key_code - 4'd10);
              r_op_valid  <= 1'b1;
              r_value     <= '0;
              r_digit_cnt <= 3'd0;
            end
          endcase
        end
      end
    end
  end

  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign value     = r_value;
  assign digit_cnt = r_digit_cnt;
  assign operand   = r_operand;
  assign op_code   = r_op_code;
  assign op_valid  = r_op_valid;
  assign enter     = r_enter;
  assign overflow  = r_overflow;

endmodule
